opcode_decode_queue: RTL and testbench

Registered, flow-controlled instruction decode stage that replaces the free-running field decoder between fetch and the register-read stage. It accepts 32-bit instruction words with a valid/ready handshake and decodes all four encodings (A–D). It sign- or zero-extends immediates to a parametrised width, flags opcodes outside a legality mask, and stores the decoded records in a small FIFO. This lets fetch run ahead of a stalled execute.

---
 rtl/opcode_decode_queue.sv | 131 +++++++++++++
 tb/tb_opcode_decode_queue.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/opcode_decode_queue.sv
// rtl/opcode_decode_queue.sv - registered instruction decode stage with a decoded-record FIFO
module opcode_decode_queue #(
    parameter int          IMM_WIDTH         = 32,
    parameter int          PC_WIDTH          = 32,
    parameter int          DEPTH             = 2,
    parameter logic [63:0] OPCODE_VALID_MASK = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic                         Clock,
    input  logic                         Reset_n,
    input  logic                         Flush,
    input  logic                         InValid,
    output logic                         InReady,
    input  logic [31:0]                  Instruction,
    input  logic [PC_WIDTH-1:0]          InPc,
    output logic                         OutValid,
    input  logic                         OutReady,
    output logic [PC_WIDTH-1:0]          OutPc,
    output logic [5:0]                   OutOpcode,
    output logic [1:0]                   OutEncoding,
    output logic [1:0]                   OutVariant,
    output logic [5:0]                   OutReg1,
    output logic [5:0]                   OutReg2,
    output logic [5:0]                   OutReg3,
    output logic [IMM_WIDTH-1:0]         OutImm,
    output logic [1:0]                   OutOperandSize,
    output logic                         OutIllegal,
    output logic [$clog2(DEPTH):0]       Count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef struct packed {
        logic [PC_WIDTH-1:0]  pc;
        logic [5:0]           opcode;
        logic [1:0]           encoding;
        logic [1:0]           variant;
        logic [5:0]           reg1;
        logic [5:0]           reg2;
        logic [5:0]           reg3;
        logic [IMM_WIDTH-1:0] imm;
        logic [1:0]           operand_size;
        logic                 illegal;
    } record_t;

    logic [7:0] b1, b2, b3, b4;
    record_t    dec;
    record_t    head;
    record_t    mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic          push, pop;

    assign b1 = Instruction[31:24];
    assign b2 = Instruction[23:16];
    assign b3 = Instruction[15:8];
    assign b4 = Instruction[7:0];

    // Fields an encoding does not use stay at the '0 default.
    always_comb begin
        dec          = '0;
        dec.pc       = InPc;
        dec.opcode   = b1[5:0];
        dec.encoding = b1[7:6];
        dec.variant  = b2[1:0];
        dec.reg1     = b2[7:2];
        dec.illegal  = ~OPCODE_VALID_MASK[b1[5:0]];
        case (b1[7:6])
            2'd0: begin
                dec.reg2         = b3[5:0];
                dec.reg3         = {b4[3:0], b3[7:6]};
                dec.operand_size = b4[7:6];
            end
            2'd1: begin
                dec.imm = IMM_WIDTH'({b4, b3});
            end
            2'd2: begin
                dec.reg2         = b3[5:0];
                dec.imm          = IMM_WIDTH'($signed({b4[5:0], b3, b2[7:2]}));
                dec.operand_size = b4[7:6];
            end
            default: begin
                dec.reg2         = b3[5:0];
                dec.imm          = IMM_WIDTH'($signed({b4[5:0], b3[7:6]}));
                dec.operand_size = b4[7:6];
            end
        endcase
    end

    assign OutValid = (count != '0);
    assign InReady  = Flush | (count < DEPTH_C) | OutReady;
    assign push     = InValid & InReady & ~Flush;
    assign pop      = OutValid & OutReady & ~Flush;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (Flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // When full, a push lands in the slot being popped; the head is read before the edge.
    always_ff @(posedge Clock) begin
        if (push) mem[wr_ptr] <= dec;
    end

    assign head = OutValid ? mem[rd_ptr] : '0;

    assign OutPc          = head.pc;
    assign OutOpcode      = head.opcode;
    assign OutEncoding    = head.encoding;
    assign OutVariant     = head.variant;
    assign OutReg1        = head.reg1;
    assign OutReg2        = head.reg2;
    assign OutReg3        = head.reg3;
    assign OutImm         = head.imm;
    assign OutOperandSize = head.operand_size;
    assign OutIllegal     = head.illegal;
    assign Count          = count;

endmodule

// File: tb/tb_opcode_decode_queue.sv
// tb/tb_opcode_decode_queue.sv - directed vector bench for opcode_decode_queue
module tb_opcode_decode_queue;

    logic        Clock = 1'b0;
    logic        Reset_n, Flush, InValid, InReady, OutValid, OutReady, OutIllegal;
    logic [31:0] Instruction, InPc, OutPc, OutImm;
    logic [5:0]  OutOpcode, OutReg1, OutReg2, OutReg3;
    logic [1:0]  OutEncoding, OutVariant, OutOperandSize, Count;

    int vectors = 0;
    int miscompares = 0;

    opcode_decode_queue #(
        .IMM_WIDTH(32), .PC_WIDTH(32), .DEPTH(2),
        .OPCODE_VALID_MASK(64'hFFFF_FFFF_FFFF_FF7F)
    ) dut (
        .Clock(Clock), .Reset_n(Reset_n), .Flush(Flush),
        .InValid(InValid), .InReady(InReady), .Instruction(Instruction), .InPc(InPc),
        .OutValid(OutValid), .OutReady(OutReady), .OutPc(OutPc),
        .OutOpcode(OutOpcode), .OutEncoding(OutEncoding), .OutVariant(OutVariant),
        .OutReg1(OutReg1), .OutReg2(OutReg2), .OutReg3(OutReg3), .OutImm(OutImm),
        .OutOperandSize(OutOperandSize), .OutIllegal(OutIllegal), .Count(Count)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [5:0]  opcode;
        logic [1:0]  enc;
        logic [1:0]  variant;
        logic [5:0]  reg1;
        logic [5:0]  reg2;
        logic [5:0]  reg3;
        logic [31:0] imm;
        logic [1:0]  size;
        logic        illegal;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_head(input vec_t v);
        check("valid",   64'(OutValid), 64'd1);
        check("pc",      64'(OutPc), 64'(v.pc));
        check("opcode",  64'(OutOpcode), 64'(v.opcode));
        check("enc",     64'(OutEncoding), 64'(v.enc));
        check("variant", 64'(OutVariant), 64'(v.variant));
        check("reg1",    64'(OutReg1), 64'(v.reg1));
        check("reg2",    64'(OutReg2), 64'(v.reg2));
        check("reg3",    64'(OutReg3), 64'(v.reg3));
        check("imm",     64'(OutImm), 64'(v.imm));
        check("size",    64'(OutOperandSize), 64'(v.size));
        check("illegal", 64'(OutIllegal), 64'(v.illegal));
    endtask

    task automatic push_word(input logic [31:0] w, input logic [31:0] pc);
        InValid = 1'b1;
        Instruction = w;
        InPc = pc;
    endtask

    initial begin
        //                instr          pc      op     enc   var   reg1   reg2   reg3   imm            size  ill
        vecs[0] = '{32'h050DEA85, 32'h100, 6'd5,  2'd0, 2'd1, 6'd3,  6'h2A, 6'h17, 32'h0,         2'd2, 1'b0};
        vecs[1] = '{32'h42043412, 32'h104, 6'd2,  2'd1, 2'd0, 6'd1,  6'h0,  6'h0,  32'h00001234,  2'd0, 1'b0};
        vecs[2] = '{32'h83000020, 32'h108, 6'd3,  2'd2, 2'd0, 6'd0,  6'h0,  6'h0,  32'hFFF80000,  2'd0, 1'b0};
        vecs[3] = '{32'hC100803F, 32'h10C, 6'd1,  2'd3, 2'd0, 6'd0,  6'h0,  6'h0,  32'hFFFFFFFE,  2'd0, 1'b0};
        vecs[4] = '{32'h07000000, 32'h110, 6'd7,  2'd0, 2'd0, 6'd0,  6'h0,  6'h0,  32'h0,         2'd0, 1'b1};
        vecs[5] = '{32'h06000000, 32'h114, 6'd6,  2'd0, 2'd0, 6'd0,  6'h0,  6'h0,  32'h0,         2'd0, 1'b0};
        vecs[6] = '{32'h4BFFFFFF, 32'h118, 6'h0B, 2'd1, 2'd3, 6'h3F, 6'h0,  6'h0,  32'h0000FFFF,  2'd0, 1'b0};
        vecs[7] = '{32'h80FCFF1F, 32'h11C, 6'd0,  2'd2, 2'd0, 6'h3F, 6'h3F, 6'h0,  32'h0007FFFF,  2'd0, 1'b0};
        vecs[8] = '{32'hC50A479F, 32'h120, 6'd5,  2'd3, 2'd2, 6'd2,  6'h07, 6'h0,  32'h0000007D,  2'd2, 1'b0};
        vecs[9] = '{32'h87FFFFFF, 32'h124, 6'd7,  2'd2, 2'd3, 6'h3F, 6'h3F, 6'h0,  32'hFFFFFFFF,  2'd3, 1'b1};

        Reset_n = 1'b0; Flush = 1'b0; InValid = 1'b0; OutReady = 1'b0;
        Instruction = '0; InPc = '0;
        #1;
        check("rst_valid", 64'(OutValid), 64'd0);
        check("rst_count", 64'(Count), 64'd0);
        check("rst_inready", 64'(InReady), 64'd1);
        check("rst_imm", 64'(OutImm), 64'd0);
        @(negedge Clock);
        Reset_n = 1'b1;

        // Streaming: each vector is pushed while the previous one pops (Count stays 1).
        OutReady = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) begin
                check_head(vecs[i-1]);
                check("stream_count", 64'(Count), 64'd1);
            end
            push_word(vecs[i].instr, vecs[i].pc);
            @(negedge Clock);
        end
        InValid = 1'b0;
        check_head(vecs[9]);
        @(negedge Clock);
        check("drain_valid", 64'(OutValid), 64'd0);
        check("drain_count", 64'(Count), 64'd0);
        check("drain_pc_zero", 64'(OutPc), 64'd0);
        check("drain_reg1_zero", 64'(OutReg1), 64'd0);

        // Backpressure with DEPTH=2.
        OutReady = 1'b0;
        push_word(32'h01000000, 32'h200);
        @(negedge Clock);
        check("bp_count1", 64'(Count), 64'd1);
        check("bp_inready1", 64'(InReady), 64'd1);
        check("bp_latency_pc", 64'(OutPc), 64'h200);
        push_word(32'h02000000, 32'h204);
        @(negedge Clock);
        check("bp_count2", 64'(Count), 64'd2);
        check("bp_inready_full", 64'(InReady), 64'd0);
        push_word(32'h03000000, 32'h208);
        @(negedge Clock);
        check("bp_held_count", 64'(Count), 64'd2);
        check("bp_head1_pc", 64'(OutPc), 64'h200);
        check("bp_head1_stable_op", 64'(OutOpcode), 64'd1);
        OutReady = 1'b1;
        #1;
        check("bp_inready_pop", 64'(InReady), 64'd1);
        @(negedge Clock);
        InValid = 1'b0;
        check("bp_count_swap", 64'(Count), 64'd2);
        check("bp_head2_pc", 64'(OutPc), 64'h204);
        @(negedge Clock);
        check("bp_count_last", 64'(Count), 64'd1);
        check("bp_head3_pc", 64'(OutPc), 64'h208);
        check("bp_head3_op", 64'(OutOpcode), 64'd3);
        @(negedge Clock);
        check("bp_empty", 64'(Count), 64'd0);

        // Flush with a full queue plus simultaneous push and pop.
        OutReady = 1'b0;
        push_word(32'h01000000, 32'h300);
        @(negedge Clock);
        push_word(32'h02000000, 32'h304);
        @(negedge Clock);
        check("fl_pre_count", 64'(Count), 64'd2);
        Flush = 1'b1; OutReady = 1'b1;
        push_word(32'h04000000, 32'h308);
        #1;
        check("fl_inready", 64'(InReady), 64'd1);
        @(negedge Clock);
        Flush = 1'b0; InValid = 1'b0;
        check("fl_count", 64'(Count), 64'd0);
        check("fl_valid", 64'(OutValid), 64'd0);
        @(negedge Clock);
        check("fl_dropped", 64'(Count), 64'd0);

        // Asynchronous reset mid-stream.
        OutReady = 1'b0;
        push_word(32'h01000000, 32'h400);
        @(negedge Clock);
        push_word(32'h02000000, 32'h404);
        @(negedge Clock);
        InValid = 1'b0;
        check("rs_pre_count", 64'(Count), 64'd2);
        #2;
        Reset_n = 1'b0;
        #1;
        check("rs_valid", 64'(OutValid), 64'd0);
        check("rs_count", 64'(Count), 64'd0);
        check("rs_pc_zero", 64'(OutPc), 64'd0);
        @(negedge Clock);
        Reset_n = 1'b1;
        OutReady = 1'b1;
        push_word(vecs[8].instr, vecs[8].pc);
        @(negedge Clock);
        InValid = 1'b0;
        check_head(vecs[8]);
        check("rs_post_count", 64'(Count), 64'd1);
        @(negedge Clock);
        check("rs_post_empty", 64'(Count), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
